mux_rr_arb4: RTL and testbench
==============================

# mux_rr_arb4

Four-way round-robin arbiter that produces the registered 2-bit select for the downstream `mux_xx2` 4:1 data mux. It grants one of four requesters for a fixed burst of beats and runs a valid/ready handshake toward the consumer. It returns per-requester accept strobes so each source advances its own data only on accepted beats. It sits directly upstream of `mux_xx2` in the coefficient-routing datapath: `sel` drives the mux select, and the mux output pairs with `o_vld`.

## Interface
- `BURST`, default 1: beats transferred per grant; legal range 1..256.
- `CW`, default 8: burst counter width; must satisfy 2^CW ≥ BURST.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 4: per-requester valid; bit i means source i presents data on mux input i.
- `ack`, output, 4: per-requester accept strobe; at most one bit high in any cycle.
- `sel`, output, 2: registered select to `mux_xx2` (0=a, 1=b, 2=c, 3=d).
- `o_vld`, output, 1: mux output is valid.
- `o_rdy`, input, 1: consumer accepts the beat.
- `busy`, output, 1: a grant is active (state GRANT).

## Operation
- Reset values: state IDLE, `sel`=0, `ptr`=0, `cnt`=0, `o_vld`=0, `ack`=0, `busy`=0.
- Two-state FSM: IDLE and GRANT.
- IDLE, `req`==0:
  - Stay in IDLE; `sel` holds its last value.
- IDLE, `req`≠0:
  - Winner = first set bit scanning `ptr`, `ptr`+1, … modulo 4. The scan wraps from 3 to 0.
  - Register `sel`=winner, clear `cnt`=0, go to GRANT.
- GRANT outputs:
  - `o_vld` = `req[sel]`, combinational from the current `req`.
  - `ack[sel]` = `o_vld & o_rdy`; all other `ack` bits are 0.
  - `busy`=1.
- GRANT, beat accepted (`o_vld & o_rdy`) with `cnt` < BURST-1: `cnt` increments.
- GRANT, beat accepted with `cnt`==BURST-1:
  - `ptr` = `sel`+1 modulo 4.
  - Go to IDLE.
- GRANT, no beat accepted (requester deasserts `req[sel]`, or `o_rdy`=0): hold state, `cnt` and `sel`.
  - A grant is never aborted or pre-empted. Other requesters wait.
- `sel` changes only on the IDLE→GRANT transition, so the mux select is glitch-free during a burst.
- `ptr` updates only on burst completion.
- `ack` and `o_vld` are never high in IDLE.

## Timing
- Arbitration latency: if `req` is first nonzero in IDLE at cycle N, then `sel` and `busy` are valid at N+1, and `o_vld` can be high at N+1.
- Throughput: at most one beat per cycle within a burst.
- One mandatory IDLE bubble cycle follows every burst, so sustained efficiency is BURST/(BURST+1).
- With BURST=1 the block alternates GRANT and IDLE.
- Simultaneous burst completion and new requests: requests are evaluated in the following IDLE cycle using the updated `ptr`.
- Reset asserted mid-burst: all state returns to reset values asynchronously. No `ack` is produced in the reset cycle.
- After reset releases, arbitration restarts from `ptr`=0.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=1'b0, GRANT=1'b1);
  - the requester count constant (NREQ=4);
  - the select width constant (SELW=2).
- Sub-module `rr_pick4` is purely combinational.
  - Inputs: `req`[3:0], `ptr`[1:0].
  - Outputs: `any`, `win`[1:0].
  - It is instantiated once.
- The top module holds the FSM, `cnt`, `ptr` and the `sel` register.
- The `mux_xx2` instance is placed by the parent, not inside this block.

## Test plan
- **Single requester:** BURST=4, `req`=0001 held, `o_rdy`=1.
  - `sel`=0 and `o_vld`=1 for 4 cycles, with `ack`=0001 each cycle.
  - Then 1 IDLE cycle, then a regrant to 0.
- **Full contention rotation:** BURST=2, `req`=1111 held, `o_rdy`=1.
  - `sel` sequence 0,0,1,1,2,2,3,3,0,…, with one bubble between bursts.
  - `ack` is one-hot and matches `sel`.
- **Pointer wrap:** finish a burst on requester 3, then present `req`=1001.
  - The next grant goes to 0, not 3.
- **Consumer stall:** BURST=3, `o_rdy` low for 5 cycles mid-burst.
  - `ack`=0 and `cnt` frozen during the stall.
  - After `o_rdy` returns, exactly 3 total acks for the burst.
- **Requester drop:** `req[sel]` falls after 1 beat while `req`=0110 for the others.
  - `o_vld`=0, `sel` unchanged, no grant switch.
  - The burst resumes when `req[sel]` returns.
- **Reset mid-burst:** assert `rst` during beat 2 of 4.
  - All outputs at reset values immediately.
  - After release, `req`=0100 is granted at the next cycle with `ptr`=0 scan order.

Source files
------------

// File: rtl/mux_rr_arb4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arb4_pkg
//  Description : Shared constants for the mux_rr_arb4 round-robin arbiter:
//                requester count, select width and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_rr_arb4_pkg;

    // Number of requesters and width of the mux select
    localparam int c_nreq = 4;
    localparam int c_selw = 2;

    // FSM state encoding
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

endpackage : mux_rr_arb4_pkg
`default_nettype wire

// File: rtl/mux_rr_arb4_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational round-robin winner search over four requests.
//                Scans req[ptr], req[ptr+1], ... modulo 4 and reports the
//                first set bit.
//  Ports       : req [3:0] in  - request vector
//                ptr [1:0] in  - scan start position
//                any       out - at least one request is set
//                win [1:0] out - index of the winning request (valid if any)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mux_rr_arb4_pkg::*;
(
    input  logic [c_nreq-1:0] req,
    input  logic [c_selw-1:0] ptr,
    output logic              any,
    output logic [c_selw-1:0] win
);

    logic [c_selw-1:0] w_idx;
    logic              w_found;

    always_comb begin
        any     = |req;
        win     = ptr;
        w_idx   = '0;
        w_found = 1'b0;
        // The 2-bit index addition wraps 3 -> 0 naturally
        for (int k = 0; k < c_nreq; k++) begin
            w_idx = ptr + c_selw'(k);
            if (!w_found && req[w_idx]) begin
                win     = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux_rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arb4
//  Description : Four-way round-robin burst arbiter producing the registered
//                select for the downstream 4:1 data mux, with a valid/ready
//                handshake toward the consumer and per-requester accept
//                strobes.
//  Ports       : clk        in  - clock, rising edge
//                rst        in  - asynchronous active-high reset
//                req  [3:0] in  - per-requester valid
//                ack  [3:0] out - per-requester accept strobe (one-hot or 0)
//                sel  [1:0] out - registered mux select
//                o_vld      out - mux output valid
//                o_rdy      in  - consumer accepts the beat
//                busy       out - a grant is active
//  Parameters  : BURST - beats per grant (1..256)
//                CW    - burst counter width, 2**CW >= BURST
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arb4
    import mux_rr_arb4_pkg::*;
#(
    parameter int BURST = 1,
    parameter int CW    = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [c_nreq-1:0] req,
    output logic [c_nreq-1:0] ack,
    output logic [c_selw-1:0] sel,
    output logic              o_vld,
    input  logic              o_rdy,
    output logic              busy
);

    localparam logic [CW-1:0] c_last = CW'(BURST - 1);

    logic [0:0]        r_state;
    logic [c_selw-1:0] r_sel;
    logic [c_selw-1:0] r_ptr;
    logic [CW-1:0]     r_cnt;

    logic [0:0]        w_state_nxt;
    logic [c_selw-1:0] w_sel_nxt;
    logic [c_selw-1:0] w_ptr_nxt;
    logic [CW-1:0]     w_cnt_nxt;

    logic              w_any;
    logic [c_selw-1:0] w_win;
    logic              w_beat;

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .win (w_win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_beat      = 1'b0;
        o_vld       = 1'b0;
        ack         = '0;
        busy        = 1'b0;

        case (r_state)
            c_st_idle: begin
                // sel only moves here, so it is stable for the whole burst
                if (w_any) begin
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_grant;
                end
            end
            c_st_grant: begin
                busy   = 1'b1;
                o_vld  = req[r_sel];
                w_beat = req[r_sel] & o_rdy;
                if (w_beat) begin
                    ack[r_sel] = 1'b1;
                    if (r_cnt == c_last) begin
                        // Burst done: next scan starts after the last winner
                        w_ptr_nxt   = r_sel + 1'b1;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign sel = r_sel;

endmodule : mux_rr_arb4
`default_nettype wire

// File: tb/tb_mux_rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_arb4
//  Description : Directed self-checking bench for mux_rr_arb4. One instance
//                with BURST=4 covers single requester, pointer wrap, stall,
//                requester drop and reset mid-burst; a BURST=2 instance covers
//                full-contention rotation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arb4;

    logic       clk;
    logic       rst;

    logic [3:0] req4, ack4;
    logic [1:0] sel4;
    logic       vld4, rdy4, busy4;

    logic [3:0] req2, ack2;
    logic [1:0] sel2;
    logic       vld2, rdy2, busy2;

    int n_vec;
    int n_err;

    mux_rr_arb4 #(.BURST(4), .CW(8)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .req   (req4),
        .ack   (ack4),
        .sel   (sel4),
        .o_vld (vld4),
        .o_rdy (rdy4),
        .busy  (busy4)
    );

    mux_rr_arb4 #(.BURST(2), .CW(8)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .ack   (ack2),
        .sel   (sel2),
        .o_vld (vld2),
        .o_rdy (rdy2),
        .busy  (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample shortly after
    task automatic cyc4(input logic [3:0] r, input logic rd);
        @(negedge clk);
        req4 = r;
        rdy4 = rd;
        #1;
    endtask

    task automatic cyc2(input logic [3:0] r, input logic rd);
        @(negedge clk);
        req2 = r;
        rdy2 = rd;
        #1;
    endtask

    task automatic exp4(input string tag, input logic b, input logic [1:0] s,
                        input logic v, input logic [3:0] a);
        check_val({tag, "_busy"}, 32'(busy4), 32'(b));
        check_val({tag, "_sel"},  32'(sel4),  32'(s));
        check_val({tag, "_vld"},  32'(vld4),  32'(v));
        check_val({tag, "_ack"},  32'(ack4),  32'(a));
    endtask

    task automatic exp2(input string tag, input logic b, input logic [1:0] s,
                        input logic v, input logic [3:0] a);
        check_val({tag, "_busy"}, 32'(busy2), 32'(b));
        check_val({tag, "_sel"},  32'(sel2),  32'(s));
        check_val({tag, "_vld"},  32'(vld2),  32'(v));
        check_val({tag, "_ack"},  32'(ack2),  32'(a));
    endtask

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n_ack;
        logic [1:0] s;
        n_vec = 0;
        n_err = 0;
        rst  = 1'b1;
        req4 = '0; rdy4 = 1'b0;
        req2 = '0; rdy2 = 1'b0;

        #12;
        exp4("rst4", 1'b0, 2'd0, 1'b0, 4'b0000);
        exp2("rst2", 1'b0, 2'd0, 1'b0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- full contention rotation, BURST=2 ----------------
        cyc2(4'b1111, 1'b1);
        exp2("rot_idle", 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int b = 0; b < 5; b++) begin
            s = 2'(b % 4);
            for (int i = 0; i < 2; i++) begin
                cyc2(4'b1111, 1'b1);
                exp2($sformatf("rot_b%0d_%0d", b, i), 1'b1, s, 1'b1, 4'b0001 << s);
            end
            cyc2(4'b1111, 1'b1);
            exp2($sformatf("rot_bub%0d", b), 1'b0, s, 1'b0, 4'b0000);
        end
        req2 = '0;

        // ---------------- single requester, BURST=4 ----------------
        cyc4(4'b0001, 1'b1);
        exp4("t1_idle", 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc4(4'b0001, 1'b1);
            exp4($sformatf("t1_beat%0d", i), 1'b1, 2'd0, 1'b1, 4'b0001);
        end
        cyc4(4'b0001, 1'b1);
        exp4("t1_bubble", 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc4(4'b0001, 1'b1);
            exp4($sformatf("t1_regrant%0d", i), 1'b1, 2'd0, 1'b1, 4'b0001);
        end
        // ptr = 1 now

        // ---------------- pointer wrap ----------------
        cyc4(4'b1000, 1'b1);
        exp4("wrap_idle3", 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc4(4'b1000, 1'b1);
            exp4($sformatf("wrap_r3_%0d", i), 1'b1, 2'd3, 1'b1, 4'b1000);
        end
        // ptr wrapped to 0: requester 0 wins over 3
        cyc4(4'b1001, 1'b1);
        exp4("wrap_idle", 1'b0, 2'd3, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc4(4'b1001, 1'b1);
            exp4($sformatf("wrap_r0_%0d", i), 1'b1, 2'd0, 1'b1, 4'b0001);
        end
        // ptr = 1: requester 3 now wins over 0
        cyc4(4'b1001, 1'b1);
        exp4("wrap_idle2", 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc4(4'b1001, 1'b1);
            exp4($sformatf("wrap_r3b_%0d", i), 1'b1, 2'd3, 1'b1, 4'b1000);
        end
        // ptr = 0

        // ---------------- consumer stall ----------------
        n_ack = 0;
        cyc4(4'b0010, 1'b1);
        exp4("stall_idle", 1'b0, 2'd3, 1'b0, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            cyc4(4'b0010, 1'b1);
            if (ack4 != 4'b0000) n_ack++;
            exp4($sformatf("stall_pre%0d", i), 1'b1, 2'd1, 1'b1, 4'b0010);
        end
        for (int i = 0; i < 5; i++) begin
            cyc4(4'b0010, 1'b0);
            if (ack4 != 4'b0000) n_ack++;
            exp4($sformatf("stall_hold%0d", i), 1'b1, 2'd1, 1'b1, 4'b0000);
        end
        for (int i = 0; i < 2; i++) begin
            cyc4(4'b0010, 1'b1);
            if (ack4 != 4'b0000) n_ack++;
            exp4($sformatf("stall_post%0d", i), 1'b1, 2'd1, 1'b1, 4'b0010);
        end
        cyc4(4'b0000, 1'b1);
        exp4("stall_done", 1'b0, 2'd1, 1'b0, 4'b0000);
        check_val("stall_acks", 32'(n_ack), 32'd4);
        // ptr = 2

        // ---------------- requester drop ----------------
        cyc4(4'b0110, 1'b1);
        exp4("drop_idle", 1'b0, 2'd1, 1'b0, 4'b0000);
        cyc4(4'b0110, 1'b1);
        exp4("drop_beat0", 1'b1, 2'd2, 1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            cyc4(4'b0010, 1'b1);
            exp4($sformatf("drop_gap%0d", i), 1'b1, 2'd2, 1'b0, 4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            cyc4(4'b0110, 1'b1);
            exp4($sformatf("drop_resume%0d", i), 1'b1, 2'd2, 1'b1, 4'b0100);
        end
        cyc4(4'b0000, 1'b1);
        exp4("drop_done", 1'b0, 2'd2, 1'b0, 4'b0000);
        // ptr = 3

        // ---------------- reset mid-burst ----------------
        cyc4(4'b0001, 1'b1);
        exp4("rstm_idle", 1'b0, 2'd2, 1'b0, 4'b0000);
        cyc4(4'b0001, 1'b1);
        exp4("rstm_beat1", 1'b1, 2'd0, 1'b1, 4'b0001);
        cyc4(4'b0001, 1'b1);
        exp4("rstm_beat2", 1'b1, 2'd0, 1'b1, 4'b0001);
        rst = 1'b1;
        #1;
        exp4("rstm_async", 1'b0, 2'd0, 1'b0, 4'b0000);
        // With ptr back at 0, requester 2 must beat requester 3
        @(negedge clk);
        rst  = 1'b0;
        req4 = 4'b1100;
        #1;
        exp4("rstm_rel", 1'b0, 2'd0, 1'b0, 4'b0000);
        cyc4(4'b1100, 1'b1);
        exp4("rstm_regrant", 1'b1, 2'd2, 1'b1, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mux_rr_arb4
`default_nettype wire
